// File: rtl/ct_spsram_1024x144_arb.sv
// ---------------------------------------------------------------------------
// ct_spsram_1024x144_arb
//
// Purpose:
//   Arbiter and sequencer for one 1024x144 single-port SRAM macro. It shares
//   the macro between one read requester and one write requester. A read wins
//   a simultaneous request until the write has been denied STARVE_MAX times
//   in a row; the write then wins. Grants are combinational, and the SRAM
//   access happens in the same cycle as the grant. Read data comes back one
//   cycle after the grant.
//
// Build option:
//   CT_SPSRAM_ARB_INIT_EN - when defined, the block sweeps the whole array to
//   zero after reset (one write per cycle) before it issues any grant.
//   init_done shows when the sweep is over. When undefined, there is no
//   sweep logic and init_done is tied high.
//
// Ports:
//   forever_cpuclk  clock
//   cpurst_b        asynchronous active-low reset
//   rd_req/rd_addr  read request; held stable until rd_gnt
//   rd_gnt          read accepted this cycle
//   rd_data_vld     read data valid (cycle after rd_gnt)
//   rd_data         read data, forced to zero when not valid
//   wr_req/wr_addr/wr_data/wr_bmask  write request; held stable until wr_gnt
//   wr_gnt          write accepted this cycle
//   init_done       array ready; no grants are issued while low
//   sram_cen/sram_gwen/sram_a/sram_d/sram_wen  active-low SRAM controls
//   sram_q          SRAM read data, valid one cycle after a read access
// ---------------------------------------------------------------------------
module ct_spsram_1024x144_arb #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 144,
    parameter int STARVE_MAX = 4
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_data_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_bmask,
    output logic                  wr_gnt,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int                CNT_W      = 4;
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    logic                  w_run;        // arbitration is allowed
    logic                  w_sweep_wr;   // zeroing write this cycle
    logic [ADDR_WIDTH-1:0] w_sweep_addr;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_rd_data_vld;

    logic                  w_cen;
    logic                  w_gwen;
    logic [ADDR_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_d;
    logic [DATA_WIDTH-1:0] w_wen;

`ifdef CT_SPSRAM_ARB_INIT_EN
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_sweep_cnt;
    logic [ADDR_WIDTH-1:0] w_sweep_nxt;
    logic                  r_init_done;

    // State, sweep counter and init_done registers.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= {ADDR_WIDTH{1'b0}};
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_cnt <= w_sweep_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
        end
    end

    // Next-state logic: the sweep leaves INIT after writing the last address.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_cnt;
        case (r_state)
            ST_INIT: begin
                w_sweep_nxt = r_sweep_cnt + ADDR_ONE;
                if (&r_sweep_cnt) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_sweep_nxt = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // The reset is asynchronous, so qualify with it to keep the SRAM quiet
    // while reset is low, even though r_state already reads INIT.
    assign w_run        = (r_state == ST_RUN)  & cpurst_b;
    assign w_sweep_wr   = (r_state == ST_INIT) & cpurst_b;
    assign w_sweep_addr = r_sweep_cnt;
    assign init_done    = r_init_done;
`else
    // Without the sweep, grants are possible as soon as reset is released.
    assign w_run        = cpurst_b;
    assign w_sweep_wr   = 1'b0;
    assign w_sweep_addr = {ADDR_WIDTH{1'b0}};
    assign init_done    = 1'b1;
`endif

    // Arbitration: the read wins a tie until the write has waited STARVE_MAX cycles.
    always_comb begin
        w_rd_gnt = 1'b0;
        w_wr_gnt = 1'b0;
        if (w_run) begin
            if (wr_req && (!rd_req || (r_starve_cnt >= STARVE_LIM))) begin
                w_wr_gnt = 1'b1;
            end else if (rd_req) begin
                w_rd_gnt = 1'b1;
            end else begin
                w_rd_gnt = 1'b0;
                w_wr_gnt = 1'b0;
            end
        end else begin
            w_rd_gnt = 1'b0;
            w_wr_gnt = 1'b0;
        end
    end

    // Starvation counter: counts writes denied by a read; cleared by a write grant.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (w_wr_gnt) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (w_rd_gnt && wr_req) begin
            r_starve_cnt <= r_starve_cnt + CNT_ONE;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Read-data valid flag: follows the read grant by one cycle.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_rd_data_vld <= 1'b0;
        end else begin
            r_rd_data_vld <= w_rd_gnt;
        end
    end

    // SRAM control mux: sweep write, granted write, granted read, or idle.
    always_comb begin
        w_cen  = 1'b1;
        w_gwen = 1'b1;
        w_a    = {ADDR_WIDTH{1'b0}};
        w_d    = {DATA_WIDTH{1'b0}};
        w_wen  = {DATA_WIDTH{1'b1}};
        if (w_sweep_wr) begin
            w_cen  = 1'b0;
            w_gwen = 1'b0;
            w_a    = w_sweep_addr;
            w_wen  = {DATA_WIDTH{1'b0}};
        end else if (w_wr_gnt) begin
            w_cen  = 1'b0;
            w_gwen = 1'b0;
            w_a    = wr_addr;
            w_d    = wr_data;
            w_wen  = ~wr_bmask;
        end else if (w_rd_gnt) begin
            w_cen  = 1'b0;
            w_a    = rd_addr;
        end else begin
            w_cen  = 1'b1;
            w_gwen = 1'b1;
        end
    end

    assign rd_gnt      = w_rd_gnt;
    assign wr_gnt      = w_wr_gnt;
    assign rd_data_vld = r_rd_data_vld;
    assign rd_data     = r_rd_data_vld ? sram_q : {DATA_WIDTH{1'b0}};
    assign sram_cen    = w_cen;
    assign sram_gwen   = w_gwen;
    assign sram_a      = w_a;
    assign sram_d      = w_d;
    assign sram_wen    = w_wen;

endmodule
